// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared types for the push-button front end.
//   btn_state_e : per-button hold FSM state (IDLE, HOLD, REPEAT)
//   KIND_*      : command kind encoding carried on cmd_repeat
// -----------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    localparam logic KIND_PRESS  = 1'b0;
    localparam logic KIND_REPEAT = 1'b1;

endpackage : key_pkg

// File: rtl/btn_filter.sv
// -----------------------------------------------------------------------------
// btn_filter
// One button: 2-flop synchroniser, debounce counter and the IDLE/HOLD/REPEAT
// hold FSM that produces press and auto-repeat events.
//   clk, rst_n  : clock, asynchronous active-low reset
//   btn_i       : raw active-high button
//   level_o     : debounced level
//   evt_o       : one-cycle event strobe (press or repeat)
//   evt_kind_o  : kind of the strobed event (KIND_PRESS / KIND_REPEAT)
// -----------------------------------------------------------------------------
module btn_filter
    import key_pkg::*;
#(
    parameter int DEB_CYC  = 1000000,
    parameter int LONG_CYC = 50000000,
    parameter int REP_CYC  = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic evt_o,
    output logic evt_kind_o
);

    localparam int CW   = $clog2(DEB_CYC);
    localparam int HMAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
    localparam int HW   = $clog2(HMAX);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYC - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REP_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    btn_state_e    state_q;
    logic [HW-1:0] hc_q;

    // The debounced level changes on the edge where deb_done is high; the FSM
    // reacts to that same edge so events line up with the level change.
    logic deb_done;
    logic rise;
    logic fall;

    assign deb_done = (sync2_q != level_q) && (cnt_q == CNT_LAST);
    assign rise     = deb_done &&  sync2_q;
    assign fall     = deb_done && !sync2_q;
    assign level_o  = level_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, which is what makes the 2-flop chain work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (deb_done) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Hold FSM. A release takes priority over a repeat that would fall due on
    // the same edge, so a release never produces a command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= HOLD;
                        hc_q    <= '0;
                    end
                end
                HOLD: begin
                    if (fall) begin
                        state_q <= IDLE;
                        hc_q    <= '0;
                    end else if (hc_q == LONG_LAST) begin
                        state_q <= REPEAT;
                        hc_q    <= '0;
                    end else begin
                        hc_q <= hc_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state_q <= IDLE;
                        hc_q    <= '0;
                    end else if (hc_q == REP_LAST) begin
                        hc_q <= '0;
                    end else begin
                        hc_q <= hc_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    hc_q    <= '0;
                end
            endcase
        end
    end

    // The strobe decodes the same conditions the FSM acts on this edge, so the
    // event is latched into the pending bit on that very edge.
    // NOTE: outputs get defaults before the case so no latch is inferred.
    always_comb begin
        evt_o      = 1'b0;
        evt_kind_o = KIND_PRESS;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    evt_o      = 1'b1;
                    evt_kind_o = KIND_PRESS;
                end
            end
            HOLD: begin
                if (!fall && (hc_q == LONG_LAST)) begin
                    evt_o      = 1'b1;
                    evt_kind_o = KIND_REPEAT;
                end
            end
            REPEAT: begin
                if (!fall && (hc_q == REP_LAST)) begin
                    evt_o      = 1'b1;
                    evt_kind_o = KIND_REPEAT;
                end
            end
            default: ;
        endcase
    end

endmodule : btn_filter

// File: rtl/key_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// key_cmd_scheduler
// Debounces N_BTN buttons and schedules their press / auto-repeat events
// round-robin onto a single valid/ready command port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   btn_in      : raw active-high buttons
//   btn_level   : debounced levels
//   cmd_valid   : command presented
//   cmd_id      : issuing button index
//   cmd_repeat  : 0 = initial press, 1 = auto-repeat
//   cmd_ready   : consumer accepts (handshake = cmd_valid & cmd_ready)
//   ovf         : sticky per-button lost-event flag
// -----------------------------------------------------------------------------
module key_cmd_scheduler
    import key_pkg::*;
#(
    parameter int N_BTN    = 4,
    parameter int DEB_CYC  = 1000000,
    parameter int LONG_CYC = 50000000,
    parameter int REP_CYC  = 10000000,
    parameter int IDW      = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic             cmd_valid,
    output logic [IDW-1:0]   cmd_id,
    output logic             cmd_repeat,
    input  logic             cmd_ready,
    output logic [N_BTN-1:0] ovf
);

    localparam logic [IDW-1:0] ID_LAST = IDW'(N_BTN - 1);

    logic [N_BTN-1:0] evt;
    logic [N_BTN-1:0] evt_kind;

    for (genvar g = 0; g < N_BTN; g++) begin : g_filt
        btn_filter #(
            .DEB_CYC  (DEB_CYC),
            .LONG_CYC (LONG_CYC),
            .REP_CYC  (REP_CYC)
        ) u_filt (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn_i      (btn_in[g]),
            .level_o    (btn_level[g]),
            .evt_o      (evt[g]),
            .evt_kind_o (evt_kind[g])
        );
    end

    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] kind_q, kind_d;
    logic [N_BTN-1:0] ovf_q,  ovf_d;
    logic [IDW-1:0]   ptr_q;
    logic             cmd_valid_q;
    logic [IDW-1:0]   cmd_id_q;
    logic             cmd_repeat_q;

    logic             load;
    logic             any_pend;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   ptr_next;

    assign load = !cmd_valid_q || cmd_ready;

    // Round-robin search: first pending bit at ptr, ptr+1, ... with wrap.
    always_comb begin
        int j;
        j        = 0;
        any_pend = 1'b0;
        winner   = '0;
        for (int k = 0; k < N_BTN; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_BTN) begin
                j = j - N_BTN;
            end
            if (!any_pend && pend_q[j]) begin
                any_pend = 1'b1;
                winner   = IDW'(j);
            end
        end
    end

    assign ptr_next = (winner == ID_LAST) ? '0 : winner + 1'b1;

    // The winner's pending bit is cleared first, so a fresh event for the
    // button being loaded re-arms it instead of counting as an overflow.
    always_comb begin
        pend_d = pend_q;
        kind_d = kind_q;
        ovf_d  = ovf_q;
        if (load && any_pend) begin
            pend_d[winner] = 1'b0;
        end
        for (int i = 0; i < N_BTN; i++) begin
            if (evt[i]) begin
                if (pend_d[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    kind_d[i] = evt_kind[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            kind_q       <= '0;
            ovf_q        <= '0;
            ptr_q        <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_id_q     <= '0;
            cmd_repeat_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            kind_q <= kind_d;
            ovf_q  <= ovf_d;
            if (load) begin
                cmd_valid_q <= any_pend;
                if (any_pend) begin
                    cmd_id_q     <= winner;
                    cmd_repeat_q <= kind_q[winner];
                    ptr_q        <= ptr_next;
                end
            end
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_id     = cmd_id_q;
    assign cmd_repeat = cmd_repeat_q;
    assign ovf        = ovf_q;

endmodule : key_cmd_scheduler

// File: tb/tb_key_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_key_cmd_scheduler
// Directed bench for key_cmd_scheduler with DEB_CYC=4, LONG_CYC=20, REP_CYC=8.
// Edge k is the k-th rising edge after the stimulus change; outputs are
// sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_key_cmd_scheduler;

    localparam int N_BTN    = 4;
    localparam int DEB_CYC  = 4;
    localparam int LONG_CYC = 20;
    localparam int REP_CYC  = 8;
    localparam int IDW      = 2;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic [N_BTN-1:0] btn_in    = '0;
    logic             cmd_ready = 1'b1;
    logic [N_BTN-1:0] btn_level;
    logic             cmd_valid;
    logic [IDW-1:0]   cmd_id;
    logic             cmd_repeat;
    logic [N_BTN-1:0] ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    key_cmd_scheduler #(
        .N_BTN    (N_BTN),
        .DEB_CYC  (DEB_CYC),
        .LONG_CYC (LONG_CYC),
        .REP_CYC  (REP_CYC),
        .IDW      (IDW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .cmd_valid  (cmd_valid),
        .cmd_id     (cmd_id),
        .cmd_repeat (cmd_repeat),
        .cmd_ready  (cmd_ready),
        .ovf        (ovf)
    );

    // One segment: drive btn for len cycles (ready=1), expecting constant
    // outputs after each edge. ovf is expected 0 throughout the table.
    typedef struct {
        bit         rst;
        int         len;
        logic [3:0] btn;
        logic [3:0] lvl;
        logic       vld;
        logic [1:0] id;
        logic       rep;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        btn_in    = '0;
        cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input bit r, input int len, input logic [3:0] b, input logic [3:0] l,
                       input logic v, input logic [1:0] i, input logic p);
        vec_t e;
        e.rst = r; e.len = len; e.btn = b; e.lvl = l; e.vld = v; e.id = i; e.rep = p;
        tbl.push_back(e);
    endtask

    // Compares {valid, id, repeat}; id/repeat only matter when a command is expected.
    task automatic chk_cmd(input string nm, input logic v, input logic [1:0] i, input logic p);
        check(nm, 16'({cmd_valid, v ? cmd_id : 2'b00, v ? cmd_repeat : 1'b0}),
                  16'({v, i, p}));
    endtask

    int hs_count;

    initial begin
        // Single press on btn 0, held 10 cycles.
        add(1, 5,  4'b0001, 4'b0000, 0, 2'd0, 0);
        add(0, 1,  4'b0001, 4'b0001, 0, 2'd0, 0);
        add(0, 1,  4'b0001, 4'b0001, 1, 2'd0, 0);
        add(0, 3,  4'b0001, 4'b0001, 0, 2'd0, 0);
        add(0, 5,  4'b0000, 4'b0001, 0, 2'd0, 0);
        add(0, 15, 4'b0000, 4'b0000, 0, 2'd0, 0);
        // Glitch rejection on btn 1: 3 high / 3 low, five times.
        for (int k = 0; k < 5; k++) begin
            add(k == 0, 3, 4'b0010, 4'b0000, 0, 2'd0, 0);
            add(0,      3, 4'b0000, 4'b0000, 0, 2'd0, 0);
        end
        add(0, 10, 4'b0000, 4'b0000, 0, 2'd0, 0);
        // Auto-repeat on btn 2, held 60 cycles.
        add(1, 5,  4'b0100, 4'b0000, 0, 2'd0, 0);
        add(0, 1,  4'b0100, 4'b0100, 0, 2'd0, 0);
        add(0, 1,  4'b0100, 4'b0100, 1, 2'd2, 0);  // edge 7
        add(0, 19, 4'b0100, 4'b0100, 0, 2'd0, 0);
        for (int k = 0; k < 4; k++) begin
            add(0, 1, 4'b0100, 4'b0100, 1, 2'd2, 1); // edges 27, 35, 43, 51
            add(0, 7, 4'b0100, 4'b0100, 0, 2'd0, 0);
        end
        add(0, 1,  4'b0100, 4'b0100, 1, 2'd2, 1);  // edge 59
        add(0, 1,  4'b0100, 4'b0100, 0, 2'd0, 0);  // edge 60
        add(0, 5,  4'b0000, 4'b0100, 0, 2'd0, 0);
        add(0, 15, 4'b0000, 4'b0000, 0, 2'd0, 0);

        do_reset();
        check("reset_state", 16'({btn_level, ovf, cmd_valid, cmd_id, cmd_repeat}), 16'h0);

        for (int s = 0; s < tbl.size(); s++) begin
            if (tbl[s].rst) do_reset();
            for (int c = 0; c < tbl[s].len; c++) begin
                btn_in    = tbl[s].btn;
                cmd_ready = 1'b1;
                tick();
                check($sformatf("seg%0d_cyc%0d", s, c),
                      16'({btn_level, ovf, cmd_valid,
                           tbl[s].vld ? cmd_id : 2'b00, tbl[s].vld ? cmd_repeat : 1'b0}),
                      16'({tbl[s].lvl, 4'b0000, tbl[s].vld, tbl[s].id, tbl[s].rep}));
            end
        end

        // Round-robin with backpressure: btns 0, 1, 3 together.
        do_reset();
        btn_in    = 4'b1011;
        cmd_ready = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 6) begin
                check("rr_level", 16'(btn_level), 16'(4'b1011));
                chk_cmd("rr_e6", 0, 2'd0, 0);
            end
            if (e >= 7) chk_cmd($sformatf("rr_hold_e%0d", e), 1, 2'd0, 0);
            if (e == 12) btn_in = 4'b0000;
        end
        cmd_ready = 1'b1;
        tick(); chk_cmd("rr_id1", 1, 2'd1, 0);
        tick(); chk_cmd("rr_id3", 1, 2'd3, 0);
        tick(); chk_cmd("rr_idle", 0, 2'd0, 0);
        repeat (11) tick();
        btn_in = 4'b1001;
        repeat (6) tick();
        chk_cmd("rr2_e6", 0, 2'd0, 0);
        tick(); chk_cmd("rr2_first_id0", 1, 2'd0, 0);
        tick(); chk_cmd("rr2_then_id3", 1, 2'd3, 0);
        tick(); chk_cmd("rr2_idle", 0, 2'd0, 0);
        btn_in = 4'b0000;
        repeat (10) tick();

        // Overflow: btn 2 held 40 cycles with the consumer stalled.
        do_reset();
        btn_in    = 4'b0100;
        cmd_ready = 1'b0;
        hs_count  = 0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (e == 7)  chk_cmd("ovf_press", 1, 2'd2, 0);
            if (e == 33) check("ovf_before", 16'(ovf), 16'h0);
            if (e == 35) check("ovf_set", 16'(ovf), 16'(4'b0100));
            if (e == 50) chk_cmd("ovf_stalled", 1, 2'd2, 0);
            if (e == 51) chk_cmd("ovf_repeat_next", 1, 2'd2, 1);
            if (e >= 50 && cmd_ready && cmd_valid) hs_count++;
            if (e == 40) btn_in = 4'b0000;
            if (e == 50) begin
                cmd_ready = 1'b1;
                hs_count  = hs_count + int'(cmd_valid);
            end
        end
        check("ovf_cmd_count", 16'(hs_count), 16'd2);
        check("ovf_sticky", 16'(ovf), 16'(4'b0100));
        chk_cmd("ovf_drained", 0, 2'd0, 0);

        // Reset mid-operation with a command presented and btn 0 held.
        do_reset();
        btn_in    = 4'b0001;
        cmd_ready = 1'b0;
        repeat (10) tick();
        chk_cmd("rst_presented", 1, 2'd0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", 16'({btn_level, ovf, cmd_valid, cmd_id, cmd_repeat}), 16'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) begin
                chk_cmd("rst_e6_idle", 0, 2'd0, 0);
                check("rst_e6_level", 16'(btn_level), 16'(4'b0001));
            end
            if (e == 7) chk_cmd("rst_fresh_press", 1, 2'd0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_key_cmd_scheduler
